// File: rtl/special_move_detector.sv
// special_move_detector
// Samples one player's direction and attack buttons, tracks the
// up-down-left-right-left-right combo with a per-step timeout, and drives
// the attack code for the bullet stage (11 special, 01 normal, 00 idle),
// holding each non-idle code for ATTACK_HOLD cycles.
// Optional feature macro: SPECIAL_COOLDOWN_EN (blocks a new special for
// COOLDOWN cycles after one fires).
// Ports:
//   clk, rst                 clock, async active-high reset
//   btnU/btnD/btnL/btnR      debounced direction buttons (async)
//   btnC                     debounced normal-attack button (async)
//   mirrored                 player faces left: L and R swapped before matching
//   attack_state[1:0]        00 idle, 01 normal, 11 special
//   combo_progress[2:0]      correct steps so far (0..5)
//   cooldown_active          special cooldown running
module special_move_detector #(
  parameter int unsigned STEP_TIMEOUT = 50_000_000,
  parameter int unsigned ATTACK_HOLD  = 5_000_000,
  parameter int unsigned COOLDOWN     = 200_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  input  logic       mirrored,
  output logic [1:0] attack_state,
  output logic [2:0] combo_progress,
  output logic       cooldown_active
);

  localparam int unsigned CNT_W = 32;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;

  localparam logic [1:0] ATK_IDLE    = 2'b00;
  localparam logic [1:0] ATK_NORMAL  = 2'b01;
  localparam logic [1:0] ATK_SPECIAL = 2'b11;

  // Direction one-hot: bit0 U, bit1 D, bit2 L, bit3 R
  localparam logic [3:0] DIR_U = 4'b0001;
  localparam logic [3:0] DIR_D = 4'b0010;
  localparam logic [3:0] DIR_L = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b1000;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = (STEP_TIMEOUT > 0) ? CNT_W'(STEP_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] HOLD_LOAD    = (ATTACK_HOLD  > 0) ? CNT_W'(ATTACK_HOLD - 1)  : '0;

  // Button vector: bit0 U, bit1 D, bit2 L, bit3 R, bit4 C
  logic [4:0]       r_sync1, r_sync2, r_prev, r_pulse;
  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_hold;
  logic [1:0]       r_attack;
  logic [3:0]       w_dir, w_exp;
  logic [2:0]       w_dir_cnt;
  logic             w_any, w_match, w_timeout, w_fire, w_timer_clr, w_cool_block;

  // Two-flop synchroniser plus rising-edge register: one pulse per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= {btnC, btnR, btnL, btnD, btnU};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  // Facing-relative directions: mirrored swaps L and R
  assign w_dir     = mirrored ? {r_pulse[2], r_pulse[3], r_pulse[1], r_pulse[0]} : r_pulse[3:0];
  assign w_dir_cnt = 3'(w_dir[0]) + 3'(w_dir[1]) + 3'(w_dir[2]) + 3'(w_dir[3]);
  assign w_any     = |w_dir;
  assign w_timeout = (r_state != S0) && (r_timer >= TIMEOUT_LAST);

  // Expected step per combo state
  always_comb begin
    w_exp = 4'b0000;
    case (r_state)
      S0:      w_exp = DIR_U;
      S1:      w_exp = DIR_D;
      S2:      w_exp = DIR_L;
      S3:      w_exp = DIR_R;
      S4:      w_exp = DIR_L;
      S5:      w_exp = DIR_R;
      default: w_exp = 4'b0000;
    endcase
  end

  assign w_match = (w_dir_cnt == 3'd1) && (w_dir == w_exp);

  // Combo next-state; a pulse in the timeout cycle wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_timer_clr = 1'b0;
    if (w_any) begin
      w_timer_clr = 1'b1;
      if (w_match) begin
        if (r_state == S5) begin
          w_state_nxt = S0;
          w_fire      = ~w_cool_block;
        end else begin
          w_state_nxt = r_state + 3'd1;
        end
      end else if (w_dir == DIR_U) begin
        w_state_nxt = S1;
      end else begin
        w_state_nxt = S0;
      end
    end else if (w_timeout) begin
      w_state_nxt = S0;
      w_timer_clr = 1'b1;
    end
  end

  // Combo state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S0;
    else     r_state <= w_state_nxt;
  end

  // Step timer, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else if ((r_state != S0) && (r_timer != '1)) begin
      r_timer <= r_timer + CNT_W'(1);
    end
  end

  // Attack code and hold; special overrides, btnC ignored while holding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_attack <= ATK_IDLE;
      r_hold   <= '0;
    end else if (w_fire) begin
      r_attack <= ATK_SPECIAL;
      r_hold   <= HOLD_LOAD;
    end else if (r_attack == ATK_IDLE) begin
      if (r_pulse[4]) begin
        r_attack <= ATK_NORMAL;
        r_hold   <= HOLD_LOAD;
      end
    end else if (r_hold == '0) begin
      r_attack <= ATK_IDLE;
    end else begin
      r_hold <= r_hold - CNT_W'(1);
    end
  end

`ifdef SPECIAL_COOLDOWN_EN
  localparam logic [CNT_W-1:0] COOL_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

  logic [CNT_W-1:0] r_cool;
  logic             r_cool_act;

  // Cooldown window after each special fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cool     <= '0;
      r_cool_act <= 1'b0;
    end else if (w_fire) begin
      r_cool     <= COOL_LOAD;
      r_cool_act <= 1'b1;
    end else if (r_cool_act) begin
      if (r_cool == '0) r_cool_act <= 1'b0;
      else              r_cool     <= r_cool - CNT_W'(1);
    end
  end

  assign w_cool_block    = r_cool_act;
  assign cooldown_active = r_cool_act;
`else
  assign w_cool_block    = 1'b0;
  assign cooldown_active = 1'b0;
`endif

  assign attack_state   = r_attack;
  assign combo_progress = r_state;

endmodule

// File: tb/tb_special_move_detector.sv
// Directed bench for special_move_detector with STEP_TIMEOUT=20,
// ATTACK_HOLD=4, COOLDOWN=30. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_special_move_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnU, btnD, btnL, btnR, btnC, mirrored;
  logic [1:0] attack_state;
  logic [2:0] combo_progress;
  logic       cooldown_active;

  int checks = 0;
  int errors = 0;

  // Button masks: bit0 U, bit1 D, bit2 L, bit3 R, bit4 C
  localparam logic [4:0] M_U = 5'b00001;
  localparam logic [4:0] M_D = 5'b00010;
  localparam logic [4:0] M_L = 5'b00100;
  localparam logic [4:0] M_R = 5'b01000;

  special_move_detector #(
    .STEP_TIMEOUT(20),
    .ATTACK_HOLD (4),
    .COOLDOWN    (30)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btnU           (btnU),
    .btnD           (btnD),
    .btnL           (btnL),
    .btnR           (btnR),
    .btnC           (btnC),
    .mirrored       (mirrored),
    .attack_state   (attack_state),
    .combo_progress (combo_progress),
    .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] m);
    btnU = m[0];
    btnD = m[1];
    btnL = m[2];
    btnR = m[3];
    btnC = m[4];
  endtask

  // Hold buttons for 4 clocks; the press takes effect on the 4th edge,
  // and the task returns on the falling edge right after it.
  task automatic press(input logic [4:0] m, input int gap);
    repeat (gap) @(negedge clk);
    set_btns(m);
    repeat (4) @(negedge clk);
    set_btns(5'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic combo(input int gap);
    press(M_U, gap);
    press(M_D, gap);
    press(M_L, gap);
    press(M_R, gap);
    press(M_L, gap);
    press(M_R, gap);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mirrored = 1'b0;
    set_btns(5'b0);
    idle(2);
    check("rst_attack", 8'(attack_state), 8'h0);
    check("rst_progress", 8'(combo_progress), 8'h0);
    check("rst_cooldown", 8'(cooldown_active), 8'h0);
    rst = 1'b0;
    idle(2);

    // Plain combo, 5 cycles between presses
    press(M_U, 1); check("c1_p1", 8'(combo_progress), 8'h1);
    press(M_D, 1); check("c1_p2", 8'(combo_progress), 8'h2);
    press(M_L, 1); check("c1_p3", 8'(combo_progress), 8'h3);
    press(M_R, 1); check("c1_p4", 8'(combo_progress), 8'h4);
    press(M_L, 1); check("c1_p5", 8'(combo_progress), 8'h5);
    @(negedge clk);
    set_btns(M_R);
    repeat (3) @(negedge clk);
    check("c1_pre_fire_atk", 8'(attack_state), 8'h0);
    check("c1_pre_fire_prog", 8'(combo_progress), 8'h5);
    @(negedge clk);
    set_btns(5'b0);
    check("c1_fire_atk", 8'(attack_state), 8'h3);
    check("c1_fire_prog", 8'(combo_progress), 8'h0);
`ifdef SPECIAL_COOLDOWN_EN
    check("c1_cool_on", 8'(cooldown_active), 8'h1);
`else
    check("c1_cool_tied", 8'(cooldown_active), 8'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("c1_hold", 8'(attack_state), 8'h3);
    end
    @(negedge clk);
    check("c1_hold_end", 8'(attack_state), 8'h0);
    idle(35);

    // Mirrored: physical U,D,R,L,R,L fires
    mirrored = 1'b1;
    press(M_U, 1); press(M_D, 1); press(M_R, 1);
    press(M_L, 1); press(M_R, 1); press(M_L, 1);
    check("mir_fire", 8'(attack_state), 8'h3);
    idle(5);
    check("mir_hold_end", 8'(attack_state), 8'h0);
    // Mirrored: physical U,D,L fails at the third press
    press(M_U, 1); check("mir_bad_p1", 8'(combo_progress), 8'h1);
    press(M_D, 1); check("mir_bad_p2", 8'(combo_progress), 8'h2);
    press(M_L, 1); check("mir_bad_p3", 8'(combo_progress), 8'h0);
    mirrored = 1'b0;
    idle(35);

    // Step timeout: progress 2 drops after 20 idle cycles
    press(M_U, 1);
    press(M_D, 1);
    check("to_start", 8'(combo_progress), 8'h2);
    idle(19);
    check("to_before", 8'(combo_progress), 8'h2);
    idle(1);
    check("to_expired", 8'(combo_progress), 8'h0);
    idle(5);
    press(M_L, 1);
    check("to_late_L", 8'(combo_progress), 8'h0);
    check("to_late_atk", 8'(attack_state), 8'h0);

    // U,D,U restarts at 1
    press(M_U, 1);
    press(M_D, 1);
    press(M_U, 1);
    check("restart_U", 8'(combo_progress), 8'h1);
    idle(25);
    check("restart_timeout", 8'(combo_progress), 8'h0);

    // Normal attack; second btnC during the hold is ignored
    btnC = 1'b1;
    @(negedge clk); btnC = 1'b0;
    @(negedge clk);
    @(negedge clk); btnC = 1'b1;
    check("n_pre", 8'(attack_state), 8'h0);
    @(negedge clk); check("n_h0", 8'(attack_state), 8'h1);
    @(negedge clk); check("n_h1", 8'(attack_state), 8'h1);
    @(negedge clk); btnC = 1'b0;
    check("n_h2", 8'(attack_state), 8'h1);
    @(negedge clk); check("n_h3", 8'(attack_state), 8'h1);
    @(negedge clk); check("n_end", 8'(attack_state), 8'h0);
    @(negedge clk); check("n_no_retrig0", 8'(attack_state), 8'h0);
    @(negedge clk); check("n_no_retrig1", 8'(attack_state), 8'h0);
    check("n_prog", 8'(combo_progress), 8'h0);

    // Two simultaneous directions at progress 3
    press(M_U, 1);
    press(M_D, 1);
    press(M_L, 1);
    check("multi_p3", 8'(combo_progress), 8'h3);
    press(M_U | M_L, 1);
    check("multi_reset", 8'(combo_progress), 8'h0);
    idle(35);

`ifdef SPECIAL_COOLDOWN_EN
    // Second combo inside the cooldown window is discarded
    combo(1);
    check("cd_fire", 8'(attack_state), 8'h3);
    check("cd_active", 8'(cooldown_active), 8'h1);
    combo(0);
    check("cd_blocked_atk", 8'(attack_state), 8'h0);
    check("cd_blocked_prog", 8'(combo_progress), 8'h0);
    check("cd_still_active", 8'(cooldown_active), 8'h1);
    idle(5);
    check("cd_last_cycle", 8'(cooldown_active), 8'h1);
    idle(1);
    check("cd_expired", 8'(cooldown_active), 8'h0);
    combo(1);
    check("cd_refire", 8'(attack_state), 8'h3);
    idle(35);
`endif

    // Asynchronous reset during a special hold
    combo(1);
    check("rh_fire", 8'(attack_state), 8'h3);
    #2 rst = 1'b1;
    #1;
    check("rh_attack", 8'(attack_state), 8'h0);
    check("rh_progress", 8'(combo_progress), 8'h0);
    check("rh_cooldown", 8'(cooldown_active), 8'h0);
    @(negedge clk); rst = 1'b0;

    // Asynchronous reset at progress 4
    press(M_U, 1); press(M_D, 1); press(M_L, 1); press(M_R, 1);
    check("rp_before", 8'(combo_progress), 8'h4);
    #2 rst = 1'b1;
    #1;
    check("rp_progress", 8'(combo_progress), 8'h0);
    check("rp_attack", 8'(attack_state), 8'h0);
    @(negedge clk); rst = 1'b0;
    idle(2);
    check("rp_after", 8'(combo_progress), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/special_move_detector.md
# special_move_detector

Upstream producer of the `attack_state` code consumed by the bullet/projectile stage. It samples one player's direction and attack pushbuttons, runs a timed combo state machine for the up-down-left-right-left-right special move, and drives `attack_state`. The code is 2'b11 for a special move, 2'b01 for a normal attack, and 2'b00 otherwise. Each code is held long enough for the bullet stage's slower sampling clock to capture it.

## Interface
Parameters:
- `STEP_TIMEOUT`, default 50_000_000: max `clk` cycles allowed between consecutive combo steps.
- `ATTACK_HOLD`, default 5_000_000: cycles a non-idle `attack_state` is held.
- `COOLDOWN`, default 200_000_000: cycles after a special fires during which no new special may fire (only when `SPECIAL_COOLDOWN_EN` is defined).

Ports:
- `clk` input 1: system clock. One clock only.
- `rst` input 1: reset, asynchronous, active-high.
- `btnU`, `btnD`, `btnL`, `btnR` input 1 each: debounced direction buttons, asynchronous to `clk`.
- `btnC` input 1: debounced normal-attack button, asynchronous.
- `mirrored` input 1: player faces left. When 1, L and R are swapped before matching, so the combo is facing-relative.
- `attack_state` output 2: 00 idle, 01 normal, 11 special. Code 10 is never driven.
- `combo_progress` output 3: number of correct steps so far, 0–5.
- `cooldown_active` output 1: special cooldown is running.

## Operation
- Each button passes through a 2-flop synchroniser, then a rising-edge register. This produces a one-cycle press pulse per button. A held button produces exactly one pulse.
- Direction pulses are remapped by `mirrored`. The value of `mirrored` is sampled in the same cycle as the pulse.
- Combo FSM has states S0–S5, where the state index equals `combo_progress`. Expected step per state: S0=U, S1=D, S2=L, S3=R, S4=L, S5=R.
- Exactly one direction pulse, and it matches the expected step:
  - In S0–S4, advance one state.
  - In S5, fire the special and return to S0.
- Wrong direction pulse, or two or more direction pulses in the same cycle:
  - Go to S0.
  - Exception: if the only pulse is U, go to S1 (restart).
- `btnC` pulses never affect the combo FSM.
- Step timer:
  - Cleared on every accepted step and on every transition into S0.
  - Counts while the state is not S0.
  - On reaching STEP_TIMEOUT−1 with no direction pulse, the state goes to S0.
  - A pulse arriving in that same cycle is evaluated normally and takes priority over the timeout.
- Hold counter: loaded with ATTACK_HOLD−1 when a code is issued; decrements to 0; `attack_state` returns to 00 when it expires.
- Priority rules:
  - A special fire overrides a running normal hold. The output becomes 11 and the hold counter reloads.
  - A special fire during a running special hold reloads the hold, subject to the cooldown rule.
  - A `btnC` pulse is ignored while any hold is active. There is no retrigger of a normal attack.
  - A `btnC` pulse and a special fire in the same cycle produce 11.
- Counters are 32-bit unsigned and saturate at 0; they never wrap.

## Timing
- Reset values: `attack_state`=00, `combo_progress`=0, `cooldown_active`=0. All counters, synchroniser flops and FSM state are also 0. Reset takes effect immediately and asynchronously, including mid-hold, mid-combo or mid-cooldown.
- Latency from a button's rising edge (first `clk` edge that sees it high) to its press pulse: 3 cycles.
- Latency from the final combo step's press pulse to `attack_state`=11: 1 cycle, registered.
- Latency from a `btnC` press pulse to `attack_state`=01: 1 cycle.
- `attack_state` stays non-idle for exactly ATTACK_HOLD cycles.
- `combo_progress` updates 1 cycle after the press pulse that caused the change.

## Configuration
- `SPECIAL_COOLDOWN_EN` defined:
  - A special fire loads the cooldown counter with COOLDOWN−1, and `cooldown_active`=1 until the counter reaches 0.
  - A combo completed while cooldown is active is discarded: the FSM goes to S0, there is no fire, and `attack_state` is unchanged.
  - Normal attacks are unaffected by the cooldown.
- `SPECIAL_COOLDOWN_EN` undefined:
  - No cooldown logic; `cooldown_active` is tied to 0.
  - Every completed combo fires.

## Test plan
All scenarios use STEP_TIMEOUT=20, ATTACK_HOLD=4, COOLDOWN=30.
- Reset, then press U,D,L,R,L,R, 5 cycles apart, with `mirrored`=0 → `combo_progress` steps 1..5 then 0; `attack_state`=11 for exactly 4 cycles, starting 1 cycle after the 6th press pulse; then 00.
- Same sequence with `mirrored`=1, using physical U,D,R,L,R,L → `attack_state`=11. Physical U,D,L,R,L,R → no fire; progress returns to 0 at the 3rd press.
- U,D, then 25 idle cycles, then L → progress 2 falls to 0 after 20 idle cycles; the L pulse leaves progress at 0. Separately, U,D,U → progress ends at 1.
- `btnC` pulse → `attack_state`=01 for 4 cycles. A second `btnC` pulse 2 cycles into the hold → ignored, and the output goes to 00 on schedule. U and L pulses in the same cycle at progress 3 → progress 0.
- `SPECIAL_COOLDOWN_EN` defined: fire a special, then complete the combo again within 30 cycles → no second 11, `cooldown_active`=1, progress returns to 0. Complete it again after cooldown ends → 11.
- Assert `rst` mid-hold (output 11) and at progress 4 → all outputs 0 immediately, before the next `clk` edge.
